regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//   Parametrised multi-port integer register file for the superscalar core.
//   Provides NRD combinational read ports and NWR write ports with same-cycle
//   write-to-read bypass, an optional hardwired zero register and a per-register
//   busy scoreboard. A scrub FSM clears the file one entry per cycle on flush.
//   Sits between decode/issue (reads, busy set) and writeback (writes, busy clear).
// PARAMETERS
//   XLEN      32  data width in bits
//   NREGS     32  number of registers; power of two, >= 4; AW = $clog2(NREGS)
//   NRD       2   number of read ports
//   NWR       2   number of write ports; higher index = higher priority
//   ZERO_REG  1   1: register 0 always reads 0, writes to it are dropped
// PORTS
//   clk         in   1         clock; all state updates on rising edge
//   rst         in   1         asynchronous, active-high reset
//   wr_en       in   NWR       per-port write enable
//   wr_addr     in   NWR*AW    packed write addresses; port k = [k*AW +: AW]
//   wr_data     in   NWR*XLEN  packed write data
//   rd_addr     in   NRD*AW    packed read addresses
//   rd_data     out  NRD*XLEN  packed read data, combinational
//   rd_busy     out  NRD       busy flag of each read register, combinational
//   busy_set    in   1         mark busy_addr as having a pending producer
//   busy_addr   in   AW        register to mark busy
//   busy        out  NREGS     scoreboard vector, registered
//   scrub_req   in   1         start a full clear (pulse; level also accepted)
//   ready       out  1         1 = IDLE; 0 = scrub in progress
// BEHAVIOUR
//   - Reset (async): all registers 0, busy = 0, FSM IDLE, scrub counter 0, ready = 1.
//   - Write: on clk edge, for each port with wr_en=1 and address != 0 (when ZERO_REG=1),
//     data[wr_addr] <= wr_data. Same address on multiple ports: highest port wins.
//   - Read: rd_data[i] = wr_data of highest-index port with wr_en=1 and
//     wr_addr == rd_addr[i], else data[rd_addr[i]] (zero latency, bypass).
//     Address 0 with ZERO_REG=1 returns 0 regardless of writes.
//   - Scoreboard: busy_set sets busy[busy_addr] next edge (ignored for reg 0 when
//     ZERO_REG=1). Any enabled write clears busy[wr_addr]. Set and clear of the same
//     register in one cycle: set wins (new producer issued).
//   - rd_busy[i] = busy[rd_addr[i]] & ~(same-cycle write to rd_addr[i]); a same-cycle
//     busy_set does not affect rd_busy until the next cycle. Reg 0 never busy.
//   - FSM states: IDLE, SCRUB.
//     IDLE -> SCRUB when scrub_req=1: counter <= 0, busy <= 0 on that edge.
//     SCRUB: each cycle data[counter] <= 0, counter++; on counter == NREGS-1 go IDLE.
//     Scrub takes exactly NREGS cycles; ready=0 for those cycles, 1 the cycle after.
//   - During SCRUB: wr_en and busy_set are ignored (dropped, no bypass into reads);
//     reads return stored contents (already-scrubbed entries read 0); scrub_req ignored.
//   - Counter is AW bits; no wrap beyond NREGS-1. rst mid-scrub aborts to IDLE with
//     all state cleared as in reset.
// TESTING
//   1. Reset, write 0xDEADBEEF to r5 on port0, read r5 next cycle -> 0xDEADBEEF.
//   2. Port0 writes 0x11 and port1 writes 0x22 to r7 same cycle, read r7 same cycle
//      -> 0x22 (bypass), next cycle -> 0x22 stored.
//   3. Write 0xFFFFFFFF to r0 on both ports -> rd_data for r0 = 0 same and next cycle.
//   4. busy_set r3; next cycle rd_busy=1; write r3 with busy_set r3 same cycle ->
//      busy[3] stays 1; write r3 alone -> rd_busy=0 in that cycle, busy[3]=0 next.
//   5. Fill r1..r31 with index value, pulse scrub_req -> ready=0 for 32 cycles,
//      write to r9 during scrub dropped, all regs read 0 after, busy=0.
//   6. Assert rst mid-scrub at counter=10 -> ready=1, all regs 0, FSM IDLE immediately.

Source files
------------

// File: rtl/regfile_mp.sv
// Purpose: multi-port register file with write-to-read bypass, optional zero register, busy scoreboard and scrub FSM.
// Latency: reads and rd_busy are combinational (0 cycles); writes and scoreboard updates land on the next clk edge.
// Backpressure: none on ports; ready=0 while scrubbing, and writes/busy_set presented then are dropped.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                busy_set,
  input  logic [AW-1:0]       busy_addr,
  output logic [NREGS-1:0]    busy,
  input  logic                scrub_req,
  output logic                ready
);

  localparam logic ZR = (ZERO_REG != 0);

  typedef enum logic {S_IDLE, S_SCRUB} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     cnt_q;
  logic              scrub_start;
  logic              idle;
  logic [XLEN-1:0]   mem [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [NWR-1:0]    wr_fire;
  logic              set_fire;
  logic [AW-1:0]     wa [NWR];
  logic [XLEN-1:0]   wd [NWR];
  logic [AW-1:0]     ra [NRD];

  assign idle = (state_q == S_IDLE);
  assign busy = busy_q;

  // Unpack the flat port buses into per-port arrays.
  always_comb begin
    for (int k = 0; k < NWR; k++) begin
      wa[k] = wr_addr[k*AW +: AW];
      wd[k] = wr_data[k*XLEN +: XLEN];
    end
    for (int i = 0; i < NRD; i++) begin
      ra[i] = rd_addr[i*AW +: AW];
    end
  end

  // Qualify writes and busy sets: dropped while scrubbing and, with a zero register, when aimed at r0.
  always_comb begin
    wr_fire = '0;
    for (int k = 0; k < NWR; k++) begin
      wr_fire[k] = wr_en[k] & idle & ~(ZR & (wa[k] == '0));
    end
    set_fire = busy_set & idle & ~(ZR & (busy_addr == '0));
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state and outputs; scrub_req is only honoured from IDLE.
  always_comb begin
    state_d     = state_q;
    scrub_start = 1'b0;
    ready       = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (scrub_req) begin
          state_d     = S_SCRUB;
          scrub_start = 1'b1;
        end
      end
      S_SCRUB: begin
        if (cnt_q == AW'(NREGS - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Scrub counter: zeroed on entry, advances once per scrub cycle, holds at the last entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     cnt_q <= '0;
    else if (scrub_start)                        cnt_q <= '0;
    else if (!idle && cnt_q != AW'(NREGS - 1))   cnt_q <= cnt_q + 1'b1;
  end

  // Storage: scrub clears one entry per cycle; otherwise ports apply in order so the highest index wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) mem[r] <= '0;
    end else if (!idle) begin
      mem[cnt_q] <= '0;
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (wr_fire[k]) mem[wa[k]] <= wd[k];
      end
    end
  end

  // Scoreboard next value: writes clear, a new producer set overrides, scrub entry wipes everything.
  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NWR; k++) begin
      if (wr_fire[k]) busy_d[wa[k]] = 1'b0;
    end
    if (set_fire)    busy_d[busy_addr] = 1'b1;
    if (scrub_start) busy_d = '0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // Read ports: stored value, overridden by the highest same-cycle write hit; r0 forced to zero/not busy.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_data[i*XLEN +: XLEN] = mem[ra[i]];
      rd_busy[i]              = busy_q[ra[i]];
      for (int k = 0; k < NWR; k++) begin
        if (wr_fire[k] && (wa[k] == ra[i])) begin
          rd_data[i*XLEN +: XLEN] = wd[k];
          rd_busy[i]              = 1'b0;
        end
      end
      if (ZR && (ra[i] == '0)) begin
        rd_data[i*XLEN +: XLEN] = '0;
        rd_busy[i]              = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios plus a randomized run against a behavioural model.
// Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
// The model tracks the scrub as a count of remaining cycles and a cleared-prefix index.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        busy_set;
  logic [4:0]  busy_addr;
  logic [31:0] busy;
  logic        scrub_req;
  logic        ready;

  int total = 0;
  int bad   = 0;

  // Behavioural model state.
  logic [31:0] m_mem [32];
  logic [31:0] m_busy;
  int          m_left;
  int          m_idx;

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .busy_set(busy_set), .busy_addr(busy_addr), .busy(busy),
    .scrub_req(scrub_req), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic clr_in();
    wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    busy_set = 1'b0; busy_addr = '0; scrub_req = 1'b0;
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_mem[r] = '0;
    m_busy = '0; m_left = 0; m_idx = 0;
  endtask

  // Model of one clock edge using the inputs currently applied.
  task automatic model_edge();
    logic [31:0] nb;
    logic [4:0]  a;
    if (m_left > 0) begin
      m_mem[m_idx] = '0;
      m_idx++;
      m_left--;
    end else begin
      nb = m_busy;
      for (int k = 0; k < 2; k++) begin
        if (wr_en[k]) begin
          a = wr_addr[k*5 +: 5];
          if (a != 0) m_mem[a] = wr_data[k*32 +: 32];
          nb[a] = 1'b0;
        end
      end
      if (busy_set && busy_addr != 0) nb[busy_addr] = 1'b1;
      if (scrub_req) begin
        nb = '0; m_left = 32; m_idx = 0;
      end
      m_busy = nb;
    end
  endtask

  function automatic logic [31:0] m_rd(int p);
    logic [4:0]  a;
    logic [31:0] v;
    a = rd_addr[p*5 +: 5];
    v = m_mem[a];
    if (m_left == 0)
      for (int k = 0; k < 2; k++)
        if (wr_en[k] && wr_addr[k*5 +: 5] == a) v = wr_data[k*32 +: 32];
    if (a == 0) v = '0;
    return v;
  endfunction

  function automatic logic m_rdbusy(int p);
    logic [4:0] a;
    logic       b;
    a = rd_addr[p*5 +: 5];
    b = m_busy[a];
    if (m_left == 0)
      for (int k = 0; k < 2; k++)
        if (wr_en[k] && wr_addr[k*5 +: 5] == a) b = 1'b0;
    if (a == 0) b = 1'b0;
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    clr_in();
    rst = 1'b1;
    model_reset();
    rd_addr = {5'd0, 5'd5};
    #3;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
    total++; if (busy !== 32'h0) begin bad++; $display("FAIL reset_busy got=%h exp=0", busy); end
    total++; if (rd_data[31:0] !== 32'h0) begin bad++; $display("FAIL reset_r5 got=%h exp=0", rd_data[31:0]); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    clr_in();
    wr_en = 2'b01; wr_addr[4:0] = 5'd5; wr_data[31:0] = 32'hDEADBEEF;
    tick();
    clr_in();
    rd_addr[4:0] = 5'd5;
    #2;
    total++; if (rd_data[31:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL write_read_r5 got=%h exp=deadbeef", rd_data[31:0]); end
  endtask

  task automatic test_bypass_priority();
    clr_in();
    wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11};
    rd_addr = {5'd7, 5'd7};
    #2;
    total++; if (rd_data[31:0] !== 32'h22) begin bad++; $display("FAIL bypass_p0 got=%h exp=22", rd_data[31:0]); end
    total++; if (rd_data[63:32] !== 32'h22) begin bad++; $display("FAIL bypass_p1 got=%h exp=22", rd_data[63:32]); end
    tick();
    clr_in();
    rd_addr = {5'd7, 5'd7};
    #2;
    total++; if (rd_data[31:0] !== 32'h22) begin bad++; $display("FAIL stored_r7 got=%h exp=22", rd_data[31:0]); end
  endtask

  task automatic test_zero_reg();
    clr_in();
    wr_en = 2'b11; wr_addr = '0; wr_data = {32'hFFFFFFFF, 32'hFFFFFFFF};
    rd_addr = '0;
    #2;
    total++; if (rd_data !== 64'h0) begin bad++; $display("FAIL r0_same got=%h exp=0", rd_data); end
    tick();
    clr_in();
    #2;
    total++; if (rd_data !== 64'h0) begin bad++; $display("FAIL r0_next got=%h exp=0", rd_data); end
  endtask

  task automatic test_scoreboard();
    clr_in();
    busy_set = 1'b1; busy_addr = 5'd3; rd_addr[4:0] = 5'd3;
    #2;
    total++; if (rd_busy[0] !== 1'b0) begin bad++; $display("FAIL busy_set_same got=%b exp=0", rd_busy[0]); end
    tick();
    clr_in();
    rd_addr[4:0] = 5'd3;
    #2;
    total++; if (rd_busy[0] !== 1'b1) begin bad++; $display("FAIL busy_next got=%b exp=1", rd_busy[0]); end
    total++; if (busy[3] !== 1'b1) begin bad++; $display("FAIL busy_vec3 got=%b exp=1", busy[3]); end
    wr_en = 2'b01; wr_addr[4:0] = 5'd3; wr_data[31:0] = 32'h33;
    busy_set = 1'b1; busy_addr = 5'd3;
    #2;
    total++; if (rd_busy[0] !== 1'b0) begin bad++; $display("FAIL busy_wr_mask got=%b exp=0", rd_busy[0]); end
    tick();
    clr_in();
    rd_addr[4:0] = 5'd3;
    #2;
    total++; if (busy[3] !== 1'b1) begin bad++; $display("FAIL set_wins got=%b exp=1", busy[3]); end
    wr_en = 2'b10; wr_addr[9:5] = 5'd3; wr_data[63:32] = 32'h34;
    #2;
    total++; if (rd_busy[0] !== 1'b0) begin bad++; $display("FAIL wr_clear_same got=%b exp=0", rd_busy[0]); end
    tick();
    clr_in();
    #2;
    total++; if (busy[3] !== 1'b0) begin bad++; $display("FAIL wr_clear_next got=%b exp=0", busy[3]); end
  endtask

  task automatic fill_regs();
    for (int r = 1; r < 32; r += 2) begin
      clr_in();
      wr_en = (r + 1 < 32) ? 2'b11 : 2'b01;
      wr_addr = {5'(r + 1), 5'(r)};
      wr_data = {32'(r + 1), 32'(r)};
      busy_set = 1'b1; busy_addr = 5'(r + 4);
      tick();
    end
    clr_in();
  endtask

  task automatic test_scrub();
    fill_regs();
    rd_addr = {5'd31, 5'd17};
    #2;
    total++; if (rd_data !== {32'd31, 32'd17}) begin bad++; $display("FAIL fill_check got=%h exp=%h", rd_data, {32'd31, 32'd17}); end
    scrub_req = 1'b1;
    tick();
    clr_in();
    for (int c = 0; c < 32; c++) begin
      clr_in();
      scrub_req = 1'b1;
      rd_addr[9:5] = (c == 0) ? 5'd0 : 5'(c - 1);
      if (c == 3) begin
        wr_en = 2'b11; wr_addr = {5'd9, 5'd9}; wr_data = {32'h99, 32'h98};
        rd_addr[4:0] = 5'd9;
      end
      #2;
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL scrub_ready c=%0d got=%b exp=0", c, ready); end
      total++; if (rd_data[63:32] !== 32'h0) begin bad++; $display("FAIL scrubbed_rd c=%0d got=%h exp=0", c, rd_data[63:32]); end
      if (c == 3) begin
        total++; if (rd_data[31:0] !== 32'd9) begin bad++; $display("FAIL scrub_no_bypass got=%h exp=9", rd_data[31:0]); end
      end
      tick();
    end
    clr_in();
    #2;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL scrub_done_ready got=%b exp=1", ready); end
    total++; if (busy !== 32'h0) begin bad++; $display("FAIL scrub_busy got=%h exp=0", busy); end
    for (int r = 0; r < 32; r++) begin
      rd_addr[4:0] = 5'(r);
      #1;
      total++; if (rd_data[31:0] !== 32'h0) begin bad++; $display("FAIL scrub_reg r=%0d got=%h exp=0", r, rd_data[31:0]); end
    end
    @(negedge clk);
    tick();
  endtask

  task automatic test_rst_mid_scrub();
    fill_regs();
    scrub_req = 1'b1;
    tick();
    clr_in();
    for (int c = 0; c < 10; c++) tick();
    rst = 1'b1;
    model_reset();
    #1;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b exp=1", ready); end
    total++; if (busy !== 32'h0) begin bad++; $display("FAIL rst_mid_busy got=%h exp=0", busy); end
    for (int r = 0; r < 32; r += 2) begin
      rd_addr = {5'(r + 1), 5'(r)};
      #0.1;
      total++; if (rd_data !== 64'h0) begin bad++; $display("FAIL rst_mid_reg r=%0d got=%h exp=0", r, rd_data); end
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    #2;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rst_mid_idle got=%b exp=1", ready); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      wr_en     = 2'($urandom_range(0, 3));
      wr_addr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wr_data   = {$urandom, $urandom};
      rd_addr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      busy_set  = ($urandom_range(0, 2) == 0);
      busy_addr = 5'($urandom_range(0, 7));
      scrub_req = ($urandom_range(0, 79) == 0);
      #2;
      for (int p = 0; p < 2; p++) begin
        total++; if (rd_data[p*32 +: 32] !== m_rd(p)) begin bad++; $display("FAIL rnd_rd n=%0d p=%0d got=%h exp=%h", n, p, rd_data[p*32 +: 32], m_rd(p)); end
        total++; if (rd_busy[p] !== m_rdbusy(p)) begin bad++; $display("FAIL rnd_rdbusy n=%0d p=%0d got=%b exp=%b", n, p, rd_busy[p], m_rdbusy(p)); end
      end
      total++; if (ready !== (m_left == 0)) begin bad++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, ready, (m_left == 0)); end
      tick();
      total++; if (busy !== m_busy) begin bad++; $display("FAIL rnd_busy n=%0d got=%h exp=%h", n, busy, m_busy); end
    end
    clr_in();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass_priority();
    test_zero_reg();
    test_scoreboard();
    test_scrub();
    test_rst_mid_scrub();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
